// File: rtl/des_key_sched_ctrl.sv
// des_key_sched_ctrl - sequential DES key-schedule controller.
// Loads a 64-bit key, applies PC-1, then rotates the 28-bit C/D halves once
// per accepted subkey and presents PC-2 subkeys over a valid/ready handshake.
// Encrypt mode emits K1..K16 (left rotates), decrypt emits K16..K1 (right
// rotates). Bit numbering follows DES: bit 1 is the MSB of every vector.
// Optional build macro: DES_KEY_PARITY_CHK_EN enables the odd-parity check on
// each key byte; when undefined, parity_err is tied low.
module des_key_sched_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        decrypt,
  input  logic [64:1] key_in,
  output logic [48:1] subkey,
  output logic [5:1]  subkey_idx,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic        busy,
  output logic        done,
  output logic        parity_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Table entries are DES bit numbers, first entry in the top 6 bits.
  localparam logic [56*6-1:0] PC1_TAB = {
    6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17, 6'd9,
    6'd1,  6'd58, 6'd50, 6'd42, 6'd34, 6'd26, 6'd18,
    6'd10, 6'd2,  6'd59, 6'd51, 6'd43, 6'd35, 6'd27,
    6'd19, 6'd11, 6'd3,  6'd60, 6'd52, 6'd44, 6'd36,
    6'd63, 6'd55, 6'd47, 6'd39, 6'd31, 6'd23, 6'd15,
    6'd7,  6'd62, 6'd54, 6'd46, 6'd38, 6'd30, 6'd22,
    6'd14, 6'd6,  6'd61, 6'd53, 6'd45, 6'd37, 6'd29,
    6'd21, 6'd13, 6'd5,  6'd28, 6'd20, 6'd12, 6'd4};

  localparam logic [48*6-1:0] PC2_TAB = {
    6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
    6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
    6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
    6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
    6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
    6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
    6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
    6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32};

  // C occupies cd[55:28], D occupies cd[27:0]; DES bit n lives at index 56-n.
  logic [1:0]  state_reg, state_next;
  logic [55:0] cd_reg, cd_next;
  logic [4:0]  count_reg, count_next;
  logic        mode_reg, mode_next;
  logic [55:0] pc1_w;
  logic [48:1] pc2_w;
  logic        key_bad_w;

  // True when the DES shift amount for key number n is 2 rather than 1.
  function automatic logic shift_two(input logic [4:0] n);
    return !((n == 5'd1) || (n == 5'd2) || (n == 5'd9) || (n == 5'd16));
  endfunction

  // Rotate C and D independently by 1 or 2, left (toward bit 1) or right.
  function automatic logic [55:0] rot_cd(input logic [55:0] cd, input logic left,
                                         input logic two);
    logic [27:0] c;
    logic [27:0] d;
    c = cd[55:28];
    d = cd[27:0];
    if (left) begin
      c = two ? {c[25:0], c[27:26]} : {c[26:0], c[27]};
      d = two ? {d[25:0], d[27:26]} : {d[26:0], d[27]};
    end else begin
      c = two ? {c[1:0], c[27:2]} : {c[0], c[27:1]};
      d = two ? {d[1:0], d[27:2]} : {d[0], d[27:1]};
    end
    return {c, d};
  endfunction

  genvar gi;

  // PC-1: pure wiring from key_in into the 56-bit C/D ordering.
  generate
    for (gi = 0; gi < 56; gi++) begin : g_pc1
      assign pc1_w[55-gi] = key_in[65 - PC1_TAB[(55-gi)*6 +: 6]];
    end
  endgenerate

  // PC-2: pure wiring from the C/D register into the 48-bit subkey.
  generate
    for (gi = 0; gi < 48; gi++) begin : g_pc2
      assign pc2_w[48-gi] = cd_reg[56 - PC2_TAB[(47-gi)*6 +: 6]];
    end
  endgenerate

`ifdef DES_KEY_PARITY_CHK_EN
  logic [7:0] byte_even_w;
  logic       parity_err_reg, parity_err_next;

  // A byte with an even number of ones fails the DES odd-parity rule.
  generate
    for (gi = 0; gi < 8; gi++) begin : g_par
      assign byte_even_w[gi] = ~^key_in[64-8*gi -: 8];
    end
  endgenerate
  assign key_bad_w  = |byte_even_w;
  assign parity_err = parity_err_reg;
`else
  assign key_bad_w  = 1'b0;
  assign parity_err = 1'b0;
`endif

  // Next-state logic: key load in IDLE, one rotation per accepted subkey in RUN.
  always_comb begin
    state_next = state_reg;
    cd_next    = cd_reg;
    count_next = count_reg;
    mode_next  = mode_reg;
`ifdef DES_KEY_PARITY_CHK_EN
    parity_err_next = parity_err_reg;
`endif
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          mode_next  = decrypt;
          count_next = 5'd1;
          // Decrypt starts from C0D0, which equals C16D16.
          cd_next    = decrypt ? pc1_w : rot_cd(pc1_w, 1'b1, 1'b0);
          state_next = key_bad_w ? S_DONE : S_RUN;
`ifdef DES_KEY_PARITY_CHK_EN
          parity_err_next = key_bad_w;
`endif
        end
      end
      S_RUN: begin
        if (subkey_ready) begin
          if (count_reg == 5'd16) begin
            state_next = S_DONE;
          end else begin
            count_next = count_reg + 5'd1;
            // Decrypt undoes the shift of the key just emitted.
            cd_next = mode_reg ? rot_cd(cd_reg, 1'b0, shift_two(5'd17 - count_reg))
                               : rot_cd(cd_reg, 1'b1, shift_two(count_reg + 5'd1));
          end
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // State registers with asynchronous abort to the idle values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      cd_reg    <= '0;
      count_reg <= '0;
      mode_reg  <= 1'b0;
`ifdef DES_KEY_PARITY_CHK_EN
      parity_err_reg <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      cd_reg    <= cd_next;
      count_reg <= count_next;
      mode_reg  <= mode_next;
`ifdef DES_KEY_PARITY_CHK_EN
      parity_err_reg <= parity_err_next;
`endif
    end
  end

  assign subkey_valid = (state_reg == S_RUN);
  assign busy         = subkey_valid;
  assign done         = (state_reg == S_DONE);
  assign subkey       = subkey_valid ? pc2_w : '0;
  assign subkey_idx   = !subkey_valid ? 5'd0 : (mode_reg ? (5'd17 - count_reg) : count_reg);

endmodule

// File: doc/des_key_sched_ctrl.md
Name: des_key_sched_ctrl

Overview:
Sequential DES key-schedule controller. Loads a 64-bit key, applies PC-1, then steps the 28-bit C/D halves once per accepted subkey and presents 48-bit PC-2 subkeys over a valid/ready handshake. In encrypt mode it emits K1..K16 using left rotates. In decrypt mode it emits K16..K1 using right rotates. It sits between key load and the round datapath, which consumes one subkey per round.

Parameters:
none (16 rounds, standard DES shift table: 1 for rounds 1,2,9,16; 2 otherwise)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  start request; sampled only in IDLE
decrypt  in  1  sampled with start; 0 = K1..K16, 1 = K16..K1
key_in  in  [64:1]  DES key, bit1 = MSB; sampled with start
subkey  out  [48:1]  current round key, PC-2 of the C/D register
subkey_idx  out  [5:1]  key number n of subkey (1..16); 0 when not valid
subkey_valid  out  1  subkey/subkey_idx valid
subkey_ready  in  1  consumer accepts the subkey when valid & ready
busy  out  1  high in RUN
done  out  1  one-cycle pulse after the 16th subkey is accepted
parity_err  out  1  key parity failure (see Optional Feature); 0 when feature disabled

Behaviour:
- Reset (async assert, sync release): state IDLE, C/D = 0, count = 0. Outputs: subkey_valid 0, busy 0, done 0, parity_err 0, subkey_idx 0. subkey is don't-care but is driven as 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - On start = 1, latch decrypt into a mode register and go to RUN.
  - Encrypt: C/D <= PC-1(key_in) left-rotated by 1, giving C1D1.
  - Decrypt: C/D <= PC-1(key_in) unrotated; C0D0 = C16D16.
  - count <= 1.
- RUN:
  - subkey_valid = 1 and busy = 1.
  - subkey = PC-2(C/D), combinational from the register.
  - subkey_idx = count (encrypt) or 17 - count (decrypt).
  - Latency: the first valid subkey appears the cycle after start is accepted.
- Handshake: subkey_valid & subkey_ready in a cycle = accept.
  - Without accept, subkey, subkey_idx and C/D hold stable for any number of cycles. Valid never drops while waiting.
  - On accept with count < 16, count increments.
    - Encrypt: C/D left-rotates by shift(count + 1).
    - Decrypt: C/D right-rotates by shift(17 - count), the shift of the key just emitted.
  - Back-to-back accepts yield one subkey per cycle.
  - On accept with count = 16, go to DONE. C/D are not rotated.
- DONE: for one cycle, done = 1, busy = 0 and subkey_valid = 0, then go to IDLE. done never coincides with subkey_valid.
- Rotates act on C[28:1] and D[28:1] independently; bit1 = MSB wraps to bit28 on a left rotate, and bit28 wraps to bit1 on a right rotate.
- start is ignored in RUN and DONE; there is no queuing. decrypt and key_in changes after acceptance have no effect.
- rst_n asserted mid-RUN aborts immediately to the reset values. There is no partial done.
- Invariant: after 16 encrypt accepts, the cumulative rotation is 28, so C/D equals PC-1(key).

Optional Feature:
Macro: DES_KEY_PARITY_CHK_EN.
- Defined:
  - In IDLE on start, check odd parity of each key_in byte (bits 8k-7..8k, k = 1..8).
  - Any byte with even parity: go to DONE instead of RUN and emit no subkeys. parity_err = 1 coincides with the done pulse.
  - parity_err is cleared on the next accepted start or on reset.
- Undefined: no check, and parity_err is tied 0.

Test Plan:
- Encrypt: reset, then start with decrypt = 0, key_in = 64'h133457799BBCDFF1, subkey_ready = 1.
  - Response: cycle +1 has subkey_idx = 1, subkey = 48'h1B02EFFC7072.
  - 16 consecutive valid cycles; the 16th has subkey = 48'hCB3D8B0E17F5.
  - Then a single done pulse, busy = 0.
- Decrypt: same key with decrypt = 1.
  - First subkey_idx = 16, subkey = 48'hCB3D8B0E17F5.
  - Last subkey_idx = 1, subkey = 48'h1B02EFFC7072.
  - The sequence is exactly the reverse of the encrypt scenario.
- Back-pressure: encrypt with random subkey_ready (~50%).
  - subkey and subkey_idx stay stable while ready = 0.
  - The 16 accepted subkeys match the no-stall sequence; done pulses once.
- Ignored start, then abort: pulse start with another key mid-RUN → sequence unaffected. Assert rst_n = 0 at subkey_idx = 7 → all outputs are 0 asynchronously. A fresh start after release restarts at K1.
- Parity (DES_KEY_PARITY_CHK_EN only): key_in = 64'h133457799BBCDFF0 → no subkey_valid, done = 1 with parity_err = 1. A following start with 64'h133457799BBCDFF1 clears parity_err and runs normally.
